contador_cascada: RTL and testbench

//   Synthesizable N x 4-bit cascaded counter/loadable register.

---
 rtl/contador_cascada_pkg.sv | 17 +
 rtl/contador_cascada_if.sv | 35 +++
 rtl/contador_cascada_slice4.sv | 49 ++++
 rtl/contador_cascada.sv | 65 ++++++
 tb/tb_contador_cascada.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/contador_cascada_pkg.sv
// Shared constants for the cascaded 4-bit counter: mode encodings and slice width.
// Imported by the slice, the interface, the top and the bench.
package contador_pkg;

  localparam logic [1:0] MODO_UP    = 2'b00;
  localparam logic [1:0] MODO_DOWN  = 2'b01;
  localparam logic [1:0] MODO_DOWN3 = 2'b10;
  localparam logic [1:0] MODO_LOAD  = 2'b11;

  localparam int SLICE_W = 4;

  // Total counter width for a given number of slices.
  function automatic int total_width(input int n_slices);
    return SLICE_W * n_slices;
  endfunction

endpackage

// File: rtl/contador_cascada_if.sv
// Tester <-> counter bundle: enable/mode/load data in, registered count and carries out.
// master is the tester side, slave is the counter side.
interface contador_cascada_if
  import contador_pkg::*;
#(
  parameter int N_SLICES = 4
);
  localparam int WIDTH = total_width(N_SLICES);

  logic                ENB;
  logic [1:0]          MODO;
  logic [WIDTH-1:0]    D;
  logic [WIDTH-1:0]    Q;
  logic                RCO;
  logic [N_SLICES-1:0] RCO_SLICE;

  modport master (
    output ENB,
    output MODO,
    output D,
    input  Q,
    input  RCO,
    input  RCO_SLICE
  );

  modport slave (
    input  ENB,
    input  MODO,
    input  D,
    output Q,
    output RCO,
    output RCO_SLICE
  );

endinterface

// File: rtl/contador_cascada_slice4.sv
// One combinational 4-bit counter slice: next state and carry/borrow out from state, mode and carry in.
// No registers here; the top registers every slice on the same edge.
module contador_slice4
  import contador_pkg::*;
#(
  parameter bit FIRST = 1'b0
) (
  input  logic [SLICE_W-1:0] state,
  input  logic [1:0]         mode,
  input  logic               cin,
  input  logic [SLICE_W-1:0] load,
  output logic [SLICE_W-1:0] nxt,
  output logic               cout
);

  logic [SLICE_W:0] ext;
  logic [SLICE_W:0] sub;
  logic [SLICE_W:0] sum;
  logic [SLICE_W:0] diff;

  always_comb begin
    ext = {1'b0, state};
    // Only the least significant slice subtracts 3; upper slices just propagate borrow.
    if (FIRST && mode == MODO_DOWN3)
      sub = (SLICE_W+1)'(3);
    else
      sub = {{SLICE_W{1'b0}}, cin};
    sum  = ext + {{SLICE_W{1'b0}}, cin};
    diff = ext - sub;

    nxt  = state;
    cout = 1'b0;
    case (mode)
      MODO_UP: begin
        nxt  = sum[SLICE_W-1:0];
        cout = sum[SLICE_W];
      end
      MODO_DOWN, MODO_DOWN3: begin
        nxt  = diff[SLICE_W-1:0];
        cout = diff[SLICE_W];
      end
      default: begin
        nxt  = load;
        cout = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/contador_cascada.sv
// N x 4-bit cascaded up/down/down-by-3/load counter; all outputs registered, 1 edge after sampling.
// Optional synchronous clear input CLR when CONTADOR_SYNC_CLR_EN is defined.
module contador_cascada
  import contador_pkg::*;
#(
  parameter int N_SLICES = 4
) (
  input  logic               CLK,
  input  logic               RESET_N,
`ifdef CONTADOR_SYNC_CLR_EN
  input  logic               CLR,
`endif
  contador_cascada_if.slave  bus
);

  localparam int WIDTH = total_width(N_SLICES);

  logic [WIDTH-1:0]    q_r;
  logic [WIDTH-1:0]    q_nxt;
  logic [N_SLICES-1:0] rco_r;
  logic [N_SLICES:0]   carry;
  logic                clr_now;

`ifdef CONTADOR_SYNC_CLR_EN
  assign clr_now = CLR;
`else
  assign clr_now = 1'b0;
`endif

  // The carry chain is purely combinational so every slice moves on the same edge.
  assign carry[0] = 1'b1;

  for (genvar i = 0; i < N_SLICES; i++) begin : g_slice
    contador_slice4 #(
      .FIRST (i == 0)
    ) u_slice (
      .state (q_r[SLICE_W*i +: SLICE_W]),
      .mode  (bus.MODO),
      .cin   (carry[i]),
      .load  (bus.D[SLICE_W*i +: SLICE_W]),
      .nxt   (q_nxt[SLICE_W*i +: SLICE_W]),
      .cout  (carry[i+1])
    );
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      q_r   <= '0;
      rco_r <= '0;
    end else if (clr_now) begin
      q_r   <= '0;
      rco_r <= '0;
    end else if (bus.ENB) begin
      q_r   <= q_nxt;
      rco_r <= carry[N_SLICES:1];
    end else begin
      rco_r <= '0;
    end
  end

  assign bus.Q         = q_r;
  assign bus.RCO_SLICE = rco_r;
  assign bus.RCO       = rco_r[N_SLICES-1];

endmodule

// File: tb/tb_contador_cascada.sv
// Directed bench for contador_cascada: 16-bit instance checked against a word-level scoreboard,
// plus a 4-bit instance for the single-slice wrap.
module tb_contador_cascada;
  import contador_pkg::*;

  typedef struct packed {
    logic [15:0] q;
    logic        rco;
    logic [3:0]  rs;
  } exp_t;

  logic CLK;
  logic RESET_N;
`ifdef CONTADOR_SYNC_CLR_EN
  logic CLR;
  logic CLR1;
`endif

  contador_cascada_if #(.N_SLICES(4)) bus  ();
  contador_cascada_if #(.N_SLICES(1)) bus1 ();

  contador_cascada #(.N_SLICES(4)) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
`ifdef CONTADOR_SYNC_CLR_EN
    .CLR     (CLR),
`endif
    .bus     (bus.slave)
  );

  contador_cascada #(.N_SLICES(1)) dut1 (
    .CLK     (CLK),
    .RESET_N (RESET_N),
`ifdef CONTADOR_SYNC_CLR_EN
    .CLR     (CLR1),
`endif
    .bus     (bus1.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  logic [15:0] m_q  = '0;
  logic [3:0]  m_rs = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Word-level reference: slice i carries when the low 4*(i+1) bits of the old value wrap.
  task automatic model(input logic e, input logic [1:0] m, input logic [15:0] d, input logic c);
    logic [31:0] mk;
    logic [31:0] low;
    if (c) begin
      m_q = '0; m_rs = '0;
    end else if (!e) begin
      m_rs = '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        mk  = (32'd1 << (4*(i+1))) - 32'd1;
        low = {16'd0, m_q} & mk;
        case (m)
          MODO_UP:    m_rs[i] = (low == mk);
          MODO_DOWN:  m_rs[i] = (low == 32'd0);
          MODO_DOWN3: m_rs[i] = (low < 32'd3);
          default:    m_rs[i] = 1'b0;
        endcase
      end
      case (m)
        MODO_UP:    m_q = m_q + 16'd1;
        MODO_DOWN:  m_q = m_q - 16'd1;
        MODO_DOWN3: m_q = m_q - 16'd3;
        default:    m_q = d;
      endcase
    end
  endtask

  task automatic step(input string tag, input logic e, input logic [1:0] m,
                      input logic [15:0] d, input logic c);
    exp_t x;
    exp_t obs;
    @(negedge CLK);
    bus.ENB  = e;
    bus.MODO = m;
    bus.D    = d;
`ifdef CONTADOR_SYNC_CLR_EN
    CLR = c;
`endif
    model(e, m, d, c);
    x.q = m_q; x.rco = m_rs[3]; x.rs = m_rs;
    sb.push_back(x);
    @(posedge CLK);
    #1;
    obs = {bus.Q, bus.RCO, bus.RCO_SLICE};
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      x = sb.pop_front();
      chk(tag, {11'd0, obs}, {11'd0, x});
    end
  endtask

  initial begin
    RESET_N   = 1'b0;
    bus.ENB   = 1'b0;
    bus.MODO  = MODO_UP;
    bus.D     = '0;
    bus1.ENB  = 1'b0;
    bus1.MODO = MODO_UP;
    bus1.D    = '0;
`ifdef CONTADOR_SYNC_CLR_EN
    CLR  = 1'b0;
    CLR1 = 1'b0;
`endif
    #3;
    chk("reset_q", {16'd0, bus.Q}, 32'd0);
    chk("reset_rco", {27'd0, bus.RCO, bus.RCO_SLICE}, 32'd0);
    @(negedge CLK);
    RESET_N = 1'b1;

    // Asynchronous reset in the middle of a cycle.
    step("load_1234", 1'b1, MODO_LOAD, 16'h1234, 1'b0);
    #2;
    RESET_N = 1'b0;
    #1;
    chk("async_reset_q", {16'd0, bus.Q}, 32'd0);
    chk("async_reset_rco", {27'd0, bus.RCO, bus.RCO_SLICE}, 32'd0);
    m_q = '0; m_rs = '0;
    @(negedge CLK);
    RESET_N = 1'b1;

    step("load_fff0", 1'b1, MODO_LOAD, 16'hFFF0, 1'b0);
    for (int i = 0; i < 16; i++) step("up", 1'b1, MODO_UP, 16'h0, 1'b0);

    step("load_000f", 1'b1, MODO_LOAD, 16'h000F, 1'b0);
    for (int i = 0; i < 16; i++) step("down", 1'b1, MODO_DOWN, 16'h0, 1'b0);

    step("load_0007", 1'b1, MODO_LOAD, 16'h0007, 1'b0);
    for (int i = 0; i < 4; i++) step("down3_a", 1'b1, MODO_DOWN3, 16'h0, 1'b0);
    step("load_ffff", 1'b1, MODO_LOAD, 16'hFFFF, 1'b0);
    for (int i = 0; i < 11; i++) step("down3_b", 1'b1, MODO_DOWN3, 16'h0, 1'b0);

    // A wrap followed by ENB=0: Q holds, carry pulse drops.
    step("load_ffff2", 1'b1, MODO_LOAD, 16'hFFFF, 1'b0);
    step("up_wrap", 1'b1, MODO_UP, 16'h0, 1'b0);
    step("hold_after_wrap", 1'b0, MODO_UP, 16'h0, 1'b0);

    for (int i = 0; i < 16; i++) step("load_seq", 1'b1, MODO_LOAD, 16'(i), 1'b0);
    for (int i = 0; i < 3; i++) step("hold", 1'b0, MODO_DOWN3, 16'hBEEF, 1'b0);
    chk("frozen_q", {16'd0, bus.Q}, 32'h000F);

`ifdef CONTADOR_SYNC_CLR_EN
    step("load_1234b", 1'b1, MODO_LOAD, 16'h1234, 1'b0);
    step("clr_load", 1'b1, MODO_LOAD, 16'hABCD, 1'b1);
    step("load_5555", 1'b1, MODO_LOAD, 16'h5555, 1'b0);
    step("clr_noenb", 1'b0, MODO_UP, 16'h0, 1'b1);
    step("load_ffff3", 1'b1, MODO_LOAD, 16'hFFFF, 1'b0);
    step("clr_over_wrap", 1'b1, MODO_UP, 16'h0, 1'b1);
`endif

    // Single-slice instance: F -> 0 wrap raises RCO, next increment drops it.
    @(negedge CLK);
    bus1.ENB = 1'b1; bus1.MODO = MODO_LOAD; bus1.D = 4'hF;
    @(posedge CLK); #1;
    chk("n1_load_q", {28'd0, bus1.Q}, 32'hF);
    @(negedge CLK);
    bus1.MODO = MODO_UP;
    @(posedge CLK); #1;
    chk("n1_wrap_q", {28'd0, bus1.Q}, 32'h0);
    chk("n1_wrap_rco", {30'd0, bus1.RCO, bus1.RCO_SLICE}, 32'h3);
    @(posedge CLK); #1;
    chk("n1_after_q", {28'd0, bus1.Q}, 32'h1);
    chk("n1_after_rco", {30'd0, bus1.RCO, bus1.RCO_SLICE}, 32'h0);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
